// File: rtl/single_to_int.sv
// single_to_int: IEEE-754 single to int32, truncating toward zero.
// Serial shifter, one mantissa bit per clock, saturates to 32'h80000000.
module single_to_int (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] single_val,
  input  logic        single_stb,
  output logic        single_ack,
  output logic [31:0] int_val,
  output logic        int_stb,
  input  logic        int_ack
);

  typedef enum logic [2:0] {
    GET_SINGLE,
    UNPACK,
    SPECIAL,
    CONVERT,
    PUT_INT
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       a_q, a_d;
  logic [31:0]       m_q, m_d;
  logic [31:0]       z_q, z_d;
  logic signed [9:0] e_q, e_d;
  logic              s_q, s_d;
  logic              ack_q, ack_d;
  logic              stb_q, stb_d;
  logic [31:0]       int_val_q, int_val_d;

  assign single_ack = ack_q;
  assign int_stb    = stb_q;
  assign int_val    = int_val_q;

  // next-state and datapath for the unpack/shift/pack sequence
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    z_d       = z_q;
    e_d       = e_q;
    s_d       = s_q;
    ack_d     = ack_q;
    stb_d     = stb_q;
    int_val_d = int_val_q;
    unique case (state_q)
      GET_SINGLE: begin
        ack_d = 1'b1;
        if (ack_q && single_stb) begin
          a_d     = single_val;
          ack_d   = 1'b0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        s_d     = a_q[31];
        e_d     = $signed({2'b00, a_q[30:23]}) - 10'sd127;
        m_d     = {1'b1, a_q[22:0], 8'h00};
        state_d = SPECIAL;
      end
      SPECIAL: begin
        if (a_q[30:23] == 8'hFF || e_q > 10'sd30) begin
          z_d     = 32'h8000_0000;
          state_d = PUT_INT;
        end else if (e_q < 10'sd0) begin
          z_d     = 32'h0000_0000;
          state_d = PUT_INT;
        end else begin
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (e_q == 10'sd31) begin
          z_d     = s_q ? (~m_q + 32'd1) : m_q;
          state_d = PUT_INT;
        end else begin
          m_d = m_q >> 1;
          e_d = e_q + 10'sd1;
        end
      end
      PUT_INT: begin
        stb_d     = 1'b1;
        int_val_d = z_q;
        if (stb_q && int_ack) begin
          stb_d   = 1'b0;
          state_d = GET_SINGLE;
        end
      end
      default: state_d = GET_SINGLE;
    endcase
  end

  // state and datapath registers, async active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= GET_SINGLE;
      a_q       <= '0;
      m_q       <= '0;
      z_q       <= '0;
      e_q       <= '0;
      s_q       <= 1'b0;
      ack_q     <= 1'b0;
      stb_q     <= 1'b0;
      int_val_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      z_q       <= z_d;
      e_q       <= e_d;
      s_q       <= s_d;
      ack_q     <= ack_d;
      stb_q     <= stb_d;
      int_val_q <= int_val_d;
    end
  end

endmodule

// File: tb/tb_single_to_int.sv
// tb_single_to_int: directed vectors plus a scoreboard model
// of the truncating float-to-int cast, checked every cycle.
module tb_single_to_int;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] single_val;
  logic        single_stb;
  logic        single_ack;
  logic [31:0] int_val;
  logic        int_stb;
  logic        int_ack;

  single_to_int dut (
    .clk        (clk),
    .rst        (rst),
    .single_val (single_val),
    .single_stb (single_stb),
    .single_ack (single_ack),
    .int_val    (int_val),
    .int_stb    (int_stb),
    .int_ack    (int_ack)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [31:0] f);
    int     e;
    longint mag;
    e = int'(f[30:23]) - 127;
    if (f[30:23] == 8'hFF || e > 30) return 32'h8000_0000;
    if (e < 0) return 32'h0;
    mag = longint'({1'b1, f[22:0]});
    if (e >= 23) mag = mag << (e - 23);
    else mag = mag >> (23 - e);
    return f[31] ? 32'(-mag) : 32'(mag);
  endfunction

  function automatic int lat(input logic [31:0] f);
    int e;
    e = int'(f[30:23]) - 127;
    if (f[30:23] == 8'hFF || e > 30 || e < 0) return 3;
    return 4 + 31 - e;
  endfunction

  logic [31:0] q[$];
  int          e0       = 0;
  int          lat_exp  = 0;
  int          last_lat = 0;
  logic        p_stb    = 1'b0;
  logic        p_iack   = 1'b0;
  logic [31:0] p_val    = '0;

  // scoreboard: sample between edges, predict the coming edge
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      p_stb  = 1'b0;
      p_iack = 1'b0;
    end else begin
      if (int_stb && !p_stb) begin
        last_lat = cyc - e0;
        chk("latency", last_lat, lat_exp);
      end
      if (p_stb && !p_iack) begin
        chk("hold_stb", {31'b0, int_stb}, 32'd1);
        chk("hold_val", int_val, p_val);
      end
      if (int_stb)
        chk("ack_busy", {31'b0, single_ack}, 32'd0);
      if (int_stb && int_ack) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_output: got %h want none",
                   int_val);
        end else begin
          chk("result", int_val, q.pop_front());
        end
      end
      if (single_ack && single_stb) begin
        q.push_back(model(single_val));
        e0      = cyc + 1;
        lat_exp = lat(single_val);
      end
      p_stb  = int_stb;
      p_iack = int_ack;
      p_val  = int_val;
    end
  end

  task automatic send(input logic [31:0] v);
    int n;
    n = 0;
    single_val = v;
    single_stb = 1'b1;
    while (n < 200) begin
      @(negedge clk);
      if (single_ack) break;
      n++;
    end
    if (!single_ack) begin
      n_chk++;
      $display("FAIL send_timeout: got ack 0 want 1");
    end
    @(posedge clk);
    #1 single_stb = 1'b0;
  endtask

  task automatic wait_stb();
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (int_stb) break;
      n++;
    end
    if (!int_stb) begin
      n_chk++;
      $display("FAIL stb_timeout: got stb 0 want 1");
    end
  endtask

  task automatic run(input string name, input logic [31:0] v,
                     input logic [31:0] exp);
    send(v);
    wait_stb();
    chk(name, int_val, exp);
    @(posedge clk);
    #1;
  endtask

  logic rnd_on;
  logic saw;
  logic [31:0] rv;

  initial begin
    rst        = 1'b0;
    single_val = '0;
    single_stb = 1'b0;
    int_ack    = 1'b0;
    rnd_on     = 1'b0;
    #1;
    chk("rst_ack", {31'b0, single_ack}, 32'd0);
    chk("rst_stb", {31'b0, int_stb}, 32'd0);
    chk("rst_val", int_val, 32'd0);
    chk("model_1p0", model(32'h3F80_0000), 32'h1);
    chk("model_m2p5", model(32'hC020_0000), 32'hFFFF_FFFE);
    chk("model_max", model(32'h4EFF_FFFF), 32'h7FFF_FF80);
    chk("model_mneg", model(32'hCF00_0000), 32'h8000_0000);
    chk("model_nan", model(32'h7FC0_0000), 32'h8000_0000);
    chk("model_m0", model(32'h8000_0000), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 chk("ack_first", {31'b0, single_ack}, 32'd1);

    int_ack = 1'b1;
    run("v_1p0", 32'h3F80_0000, 32'h0000_0001);
    chk("lat_1p0", last_lat, 32'd35);
    run("v_m2p5", 32'hC020_0000, 32'hFFFF_FFFE);
    run("v_0p75", 32'h3F40_0000, 32'h0);
    chk("lat_0p75", last_lat, 32'd3);
    run("v_m0", 32'h8000_0000, 32'h0);
    chk("lat_m0", last_lat, 32'd3);
    run("v_2p31", 32'h4F00_0000, 32'h8000_0000);
    run("v_m2p31", 32'hCF00_0000, 32'h8000_0000);
    run("v_inf", 32'h7F80_0000, 32'h8000_0000);
    run("v_nan", 32'h7FC0_0000, 32'h8000_0000);
    run("v_max", 32'h4EFF_FFFF, 32'h7FFF_FF80);
    chk("lat_max", last_lat, 32'd5);

    int_ack = 1'b0;
    send(32'h42C8_0000);
    wait_stb();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_val", int_val, 32'h64);
      chk("bp_stb", {31'b0, int_stb}, 32'd1);
      chk("bp_ack", {31'b0, single_ack}, 32'd0);
    end
    @(posedge clk);
    #1 int_ack = 1'b1;
    @(posedge clk);
    #1 int_ack = 1'b0;
    @(negedge clk);
    chk("turn_stb", {31'b0, int_stb}, 32'd0);
    chk("turn_ack0", {31'b0, single_ack}, 32'd0);
    @(negedge clk);
    chk("turn_ack1", {31'b0, single_ack}, 32'd1);

    int_ack = 1'b1;
    send(32'h3F80_0000);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_cv_stb", {31'b0, int_stb}, 32'd0);
    chk("arst_cv_ack", {31'b0, single_ack}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    saw = 1'b0;
    repeat (45) begin
      @(negedge clk);
      saw = saw | int_stb;
    end
    chk("no_output", {31'b0, saw}, 32'd0);

    @(posedge clk);
    #1 int_ack = 1'b0;
    send(32'h40E0_0000);
    wait_stb();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_put_stb", {31'b0, int_stb}, 32'd0);
    chk("arst_put_val", int_val, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 chk("ack_after_rst", {31'b0, single_ack}, 32'd1);
    int_ack = 1'b1;
    run("v_7", 32'h40E0_0000, 32'h7);

    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          rv = $urandom;
          if (i % 4 != 0) rv[30:23] = 8'($urandom_range(100, 160));
          if (i % 50 == 0) rv[30:23] = 8'hFF;
          send(rv);
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1 int_ack = 1'($urandom_range(0, 1));
        end
        int_ack = 1'b1;
      end
    join
    for (int n = 0; n < 200 && q.size() != 0; n++) @(posedge clk);
    chk("drain", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
